// File: rtl/carregador_de_instrucoes.sv
// Program loader: parses a 16-bit big-endian word count from a byte stream, then assembles
// big-endian 32-bit words and writes them to instruction memory while holding the CPU halted.
module carregador_de_instrucoes #(
    parameter int unsigned RAM_SIZE  = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] datain,
    output logic        busy,
    output logic        cpu_halt,
    output logic        done,
    output logic        erro
);

    typedef enum logic [2:0] {
        StOcioso,
        StTamHi,
        StTamLo,
        StDados,
        StFim,
        StErro
    } state_e;

    localparam logic [31:0] Capacity = 32'(RAM_SIZE - BASE_ADDR);
    localparam logic [31:0] BaseAddr = 32'(BASE_ADDR);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] index_q, index_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q, word_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] datain_q, datain_d;
    logic        done_q, done_d;
    logic        erro_q, erro_d;

    logic [15:0] count_new;
    logic [15:0] index_inc;

    assign count_new = {count_q[15:8], byte_in};
    assign index_inc = index_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        datain_d   = datain_q;
        done_d     = done_q;
        erro_d     = erro_q;

        unique case (state_q)
            StOcioso: begin
                if (start) begin
                    state_d = StTamHi;
                    done_d  = 1'b0;
                    erro_d  = 1'b0;
                end
            end
            StTamHi: begin
                if (byte_valid) begin
                    count_d[15:8] = byte_in;
                    state_d       = StTamLo;
                end
            end
            StTamLo: begin
                if (byte_valid) begin
                    count_d[7:0] = byte_in;
                    if ({16'd0, count_new} > Capacity) begin
                        state_d = StErro;
                        erro_d  = 1'b1;
                    end else if (count_new == 16'd0) begin
                        state_d = StFim;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = StDados;
                        index_d    = 16'd0;
                        byte_cnt_d = 2'd0;
                    end
                end
            end
            StDados: begin
                if (byte_valid) begin
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = BaseAddr + {16'd0, index_q};
                        datain_d   = {word_q, byte_in};
                        index_d    = index_inc;
                        byte_cnt_d = 2'd0;
                        if (index_inc == count_q) begin
                            state_d = StFim;
                            done_d  = 1'b1;
                        end
                    end else begin
                        // Three shifts leave the first byte in [23:16], i.e. word bits [31:24].
                        word_d     = {word_q[15:0], byte_in};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StFim:   state_d = StOcioso;
            StErro:  state_d = StOcioso;
            default: state_d = StOcioso;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StOcioso;
            count_q    <= 16'd0;
            index_q    <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 24'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            datain_q   <= 32'd0;
            done_q     <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            datain_q   <= datain_d;
            done_q     <= done_d;
            erro_q     <= erro_d;
        end
    end

    assign busy     = (state_q == StTamHi) || (state_q == StTamLo) || (state_q == StDados);
    assign cpu_halt = busy;
    assign we       = we_q;
    assign addr     = addr_q;
    assign datain   = datain_q;
    assign done     = done_q;
    assign erro     = erro_q;

endmodule

// File: tb/tb_carregador_de_instrucoes.sv
// Scoreboard bench: expected writes are queued by the stimulus, popped by per-DUT monitors.
module tb_carregador_de_instrucoes;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start0, bv0, we0, busy0, halt0, done0, erro0;
    logic [7:0]  bi0;
    logic [31:0] addr0, data0;
    logic        start1, bv1, we1, busy1, halt1, done1, erro1;
    logic [7:0]  bi1;
    logic [31:0] addr1, data1;

    carregador_de_instrucoes dut0 (
        .clk(clk), .rst(rst), .start(start0), .byte_in(bi0), .byte_valid(bv0),
        .we(we0), .addr(addr0), .datain(data0), .busy(busy0), .cpu_halt(halt0),
        .done(done0), .erro(erro0)
    );

    carregador_de_instrucoes #(.RAM_SIZE(1024), .BASE_ADDR(1020)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .byte_in(bi1), .byte_valid(bv1),
        .we(we1), .addr(addr1), .datain(data1), .busy(busy1), .cpu_halt(halt1),
        .done(done1), .erro(erro1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Entry: {last, addr, data}; last means the pulse coincides with done=1, busy=0.
    logic [64:0] exp0[$];
    logic [64:0] exp1[$];
    logic [64:0] e0, e1;
    int          log0[$];
    logic [7:0]  tx[$];
    int          mark_idx = -1;
    int          mark_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (we0 === 1'b1) begin
            log0.push_back(cyc);
            if (exp0.size() == 0) begin
                chk("unexpected_we0", {31'd0, we0}, 32'd0);
            end else begin
                e0 = exp0.pop_front();
                chk("addr0", addr0, e0[63:32]);
                chk("datain0", data0, e0[31:0]);
                chk("done0_at_we", {31'd0, done0}, {31'd0, e0[64]});
                chk("busy0_at_we", {31'd0, busy0}, {31'd0, ~e0[64]});
            end
        end
    end

    always @(negedge clk) begin
        if (we1 === 1'b1) begin
            if (exp1.size() == 0) begin
                chk("unexpected_we1", {31'd0, we1}, 32'd0);
            end else begin
                e1 = exp1.pop_front();
                chk("addr1", addr1, e1[63:32]);
                chk("datain1", data1, e1[31:0]);
                chk("done1_at_we", {31'd0, done1}, {31'd0, e1[64]});
            end
        end
    end

    task automatic drive(input int sel, input logic v, input logic [7:0] b);
        if (sel == 0) begin
            bv0 = v;
            bi0 = b;
        end else begin
            bv1 = v;
            bi1 = b;
        end
    endtask

    task automatic flush(input int sel, input int gap);
        for (int i = 0; i < tx.size(); i++) begin
            @(negedge clk);
            if (i == mark_idx) mark_cyc = cyc;
            drive(sel, 1'b1, tx[i]);
            if (gap != 0) begin
                @(negedge clk);
                drive(sel, 1'b0, 8'h00);
            end
        end
        @(negedge clk);
        drive(sel, 1'b0, 8'h00);
        tx.delete();
        mark_idx = -1;
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; bv0 = 1'b0; bi0 = 8'h00;
        start1 = 1'b0; bv1 = 1'b0; bi1 = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_we", {31'd0, we0}, 32'd0);
        chk("rst_addr", addr0, 32'd0);
        chk("rst_datain", data0, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_halt", {31'd0, halt0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_erro", {31'd0, erro0}, 32'd0);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        rst = 1'b0;

        // Reset in the middle of a word: outputs drop immediately, partial word discarded.
        pulse_start(0);
        tx = '{8'h00, 8'h02, 8'hAA, 8'hBB};
        flush(0, 1);
        chk("busy_before_rst", {31'd0, busy0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_halt", {31'd0, halt0}, 32'd0);
        chk("midrst_we", {31'd0, we0}, 32'd0);
        chk("midrst_done", {31'd0, done0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tx = '{8'hCC, 8'hDD};
        flush(0, 1);

        // Basic load with trailing bytes that must be ignored.
        pulse_start(0);
        chk("basic_busy", {31'd0, busy0}, 32'd1);
        chk("basic_halt", {31'd0, halt0}, 32'd1);
        exp0.push_back({1'b0, 32'd0, 32'h12345678});
        exp0.push_back({1'b1, 32'd1, 32'h9ABCDEF0});
        tx = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
               8'h11, 8'h22, 8'h33, 8'h44};
        flush(0, 1);
        chk("basic_done", {31'd0, done0}, 32'd1);
        chk("basic_busy_end", {31'd0, busy0}, 32'd0);
        chk("basic_halt_end", {31'd0, halt0}, 32'd0);
        chk("basic_erro", {31'd0, erro0}, 32'd0);
        chk("basic_addr_hold", addr0, 32'd1);
        chk("basic_data_hold", data0, 32'h9ABCDEF0);

        // Back-to-back strobes, N=3.
        pulse_start(0);
        chk("b2b_done_cleared", {31'd0, done0}, 32'd0);
        exp0.push_back({1'b0, 32'd0, 32'h01020304});
        exp0.push_back({1'b0, 32'd1, 32'h05060708});
        exp0.push_back({1'b1, 32'd2, 32'h090A0B0C});
        log0.delete();
        tx = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C};
        mark_idx = 2;
        flush(0, 0);
        repeat (2) @(negedge clk);
        chk("b2b_we_count", log0.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < log0.size()) chk("b2b_we_cycle", log0[i] - mark_cyc, 4 * (i + 1));
        end
        chk("b2b_done", {31'd0, done0}, 32'd1);

        // Oversize count.
        pulse_start(0);
        tx = '{8'h04, 8'h01};
        flush(0, 1);
        chk("over_erro", {31'd0, erro0}, 32'd1);
        chk("over_busy", {31'd0, busy0}, 32'd0);
        chk("over_done", {31'd0, done0}, 32'd0);
        pulse_start(0);
        chk("over_erro_cleared", {31'd0, erro0}, 32'd0);
        chk("over_restart_busy", {31'd0, busy0}, 32'd1);

        // Zero count within the session just started.
        tx = '{8'h00, 8'h00};
        flush(0, 1);
        chk("zero_done", {31'd0, done0}, 32'd1);
        chk("zero_busy", {31'd0, busy0}, 32'd0);

        // Start mid-load is ignored.
        pulse_start(0);
        exp0.push_back({1'b1, 32'd0, 32'hCAFEF00D});
        tx = '{8'h00, 8'h01, 8'hCA, 8'hFE};
        flush(0, 1);
        pulse_start(0);
        chk("ign_start_busy", {31'd0, busy0}, 32'd1);
        tx = '{8'hF0, 8'h0D};
        flush(0, 1);
        chk("ign_start_done", {31'd0, done0}, 32'd1);
        chk("ign_start_busy_end", {31'd0, busy0}, 32'd0);

        // BASE_ADDR=1020: N=4 fits exactly, N=5 overflows.
        pulse_start(1);
        tx = '{8'h00, 8'h04};
        for (int w = 0; w < 4; w++) begin
            exp1.push_back({(w == 3), 32'(1020 + w), 32'h10203040 + 32'(w)});
            tx.push_back(8'h10);
            tx.push_back(8'h20);
            tx.push_back(8'h30);
            tx.push_back(8'h40 + 8'(w));
        end
        flush(1, 0);
        chk("base_done", {31'd0, done1}, 32'd1);
        chk("base_busy", {31'd0, busy1}, 32'd0);
        chk("base_last_addr", addr1, 32'd1023);
        pulse_start(1);
        tx = '{8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
        flush(1, 1);
        chk("base_over_erro", {31'd0, erro1}, 32'd1);
        chk("base_over_done", {31'd0, done1}, 32'd0);
        chk("base_over_busy", {31'd0, busy1}, 32'd0);

        repeat (3) @(negedge clk);
        chk("pending_writes0", exp0.size(), 32'd0);
        chk("pending_writes1", exp1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/carregador_de_instrucoes.md
Name: carregador_de_instrucoes

Overview:
- Program loader: the writer side of the instruction memory's write port (we/addr/datain).
- Receives a byte stream (e.g. from the UART receiver), parses a 16-bit word count, and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive addresses.
- Holds the CPU in halt while loading and reports done or error.

Parameters:
- RAM_SIZE, 1024, number of 32-bit words in the instruction memory.
- BASE_ADDR, 0, word address of the first instruction written.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session when idle.
- byte_in  input  8  received byte; valid only when byte_valid=1.
- byte_valid  input  1  one-cycle strobe; one byte per strobe.
- we  output  1  instruction memory write enable; registered one-cycle pulse.
- addr  output  32  instruction memory word address; registered.
- datain  output  32  word to write; registered.
- busy  output  1  session in progress.
- cpu_halt  output  1  equals busy; stalls the PC while loading.
- done  output  1  load completed successfully; sticky.
- erro  output  1  word count rejected; sticky.

Behaviour:
- Reset (async, rst=1):
  - we=0, addr=0, datain=0, busy=0, cpu_halt=0, done=0, erro=0.
  - FSM goes to OCIOSO; word index=0, byte counter=0, count register=0.
  - Reset mid-session aborts: no further writes, and a partially assembled word is discarded.
- States: OCIOSO, TAM_HI, TAM_LO, DADOS, FIM, ERRO.
- OCIOSO:
  - start=1 → TAM_HI; busy=1 from the next cycle.
  - done and erro clear on the same edge.
  - byte_valid is ignored in this state.
- TAM_HI: on byte_valid, count[15:8]=byte_in → TAM_LO.
- TAM_LO: on byte_valid, count[7:0]=byte_in. Next state by count N:
  - N > RAM_SIZE-BASE_ADDR → ERRO.
  - N=0 → FIM.
  - Otherwise → DADOS with index=0 and byte counter=0.
- DADOS:
  - Bytes arrive big-endian: the first byte of each word goes to bits [31:24], the fourth to [7:0].
  - On the edge that captures the 4th byte, the outputs register: we=1, addr=BASE_ADDR+index, datain=assembled word; index increments and the byte counter wraps to 0.
  - we is high for exactly that one following cycle, then 0; addr and datain hold their values until the next write.
  - If index+1 == N on that edge, the next state is FIM. Otherwise the FSM stays in DADOS.
  - A byte_valid in the same cycle that we is high is accepted as byte 0 of the next word, so back-to-back strobes every cycle are sustained with no byte dropped.
- FIM:
  - Entered on the same edge as the final we pulse, or directly from TAM_LO when N=0.
  - Outputs: done=1, busy=0, cpu_halt=0.
  - Returns to OCIOSO on the next cycle; done stays high until the next accepted start or reset.
- ERRO:
  - Outputs: erro=1, busy=0, no writes.
  - Returns to OCIOSO on the next cycle; erro stays high until the next accepted start or reset.
- start while busy=1 is ignored, with no restart and no state change.
- Bytes beyond N words arrive after the FSM has left DADOS and are ignored.
- Arithmetic:
  - addr = BASE_ADDR + index, zero-extended to 32 bits.
  - index is 16 bits; the bound check guarantees addr < RAM_SIZE.
- Latency: 4th byte strobe at edge k → we high during cycle k+1.

Test Plan:
- Reset mid-word: rst asserted after 2 data bytes → all outputs 0 immediately, no we pulse; a fresh session then loads correctly.
- Basic load: start; bytes 00 02, 12 34 56 78, 9A BC DE F0 → we pulse with addr=0/datain=0x12345678, then addr=1/datain=0x9ABCDEF0; done=1, busy=0 after the second write.
- Back-to-back bytes: byte_valid every cycle for N=3 (12 bytes) → exactly 3 we pulses at cycles 4, 8, 12 after the first data byte; no byte lost.
- Oversize count: N=0x0401 with RAM_SIZE=1024 → erro=1, we never asserts, busy=0; the next start clears erro.
- Zero count and ignored start: N=0 → done=1 with no we pulse. A start pulse mid-load (N=1) → ignored; the word is still written at addr=BASE_ADDR.
- BASE_ADDR=1020 with N=4 → writes at addresses 1020..1023, done=1. Repeating with N=5 → erro=1, no writes.
